// File: rtl/decode_output_queue.sv
// Circular FIFO between the format decoders and dispatch, with early stall and a sticky overflow flag.
// Optional same-cycle bypass of an empty queue is enabled by defining DECODE_QUEUE_BYPASS_EN.
module decode_output_queue #(
    parameter int PayloadWidth = 227,
    parameter int Depth        = 4,
    parameter int CountWidth   = 3
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    enable_i,
    input  logic [PayloadWidth-1:0] payload_i,
    output logic                    stall_o,
    output logic                    valid_o,
    output logic [PayloadWidth-1:0] payload_o,
    input  logic                    ready_i,
    output logic [CountWidth-1:0]   count_o,
    output logic                    overflow_o
);

    localparam int PtrWidth = $clog2(Depth);

    logic [PayloadWidth-1:0] storage [Depth];
    logic [PtrWidth-1:0]     rdPtr;
    logic [PtrWidth-1:0]     wrPtr;
    logic [CountWidth-1:0]   count;
    logic                    overflow;
    logic                    isEmpty;
    logic                    isFull;
    logic                    doRead;
    logic                    doWrite;
    logic                    dropWrite;
    logic                    bypass;

    always_comb begin
        isEmpty = (count == '0);
        isFull  = (count == CountWidth'(Depth));
        doRead  = !isEmpty && ready_i;
`ifdef DECODE_QUEUE_BYPASS_EN
        bypass  = isEmpty && enable_i && ready_i;
`else
        bypass  = 1'b0;
`endif
        // A full queue still accepts a write when the head leaves on the same edge.
        doWrite   = enable_i && !bypass && (!isFull || doRead);
        dropWrite = enable_i && !bypass && !doWrite;
    end

    always_comb begin
`ifdef DECODE_QUEUE_BYPASS_EN
        valid_o   = !isEmpty || bypass;
        payload_o = bypass ? payload_i : storage[rdPtr];
`else
        valid_o   = !isEmpty;
        payload_o = storage[rdPtr];
`endif
        // One slot stays free for the instruction already inside the one-cycle decoder.
        stall_o    = (count >= CountWidth'(Depth - 1));
        count_o    = count;
        overflow_o = overflow;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doWrite && !doRead) begin
                count <= count + 1'b1;
            end else if (doRead && !doWrite) begin
                count <= count - 1'b1;
            end
            if (dropWrite) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset; only pointers and flags define what is valid.
    always_ff @(posedge clock_i) begin
        if (reset_i && !flush_i && doWrite) begin
            storage[wrPtr] <= payload_i;
        end
    end

endmodule

// File: doc/decode_output_queue.md
DECODE_OUTPUT_QUEUE -- requirements
Module: decode_output_queue

Interface
- REQ-001: Parameter PayloadWidth, default 227: packed decoded-instruction width.
- REQ-002: Parameter Depth, default 4: queue entries, power of two, >= 2.
- REQ-003: Parameter CountWidth, default 3: width of count_o, equal to log2(Depth)+1.
- REQ-004: Port clock_i, input, 1: the single clock; all state updates on its rising edge.
- REQ-005: Port reset_i, input, 1: reset is synchronous and active-low.
- REQ-006: Port flush_i, input, 1: discard all queued entries.
- REQ-007: Port enable_i, input, 1: a format decoder presents a valid decoded instruction this cycle.
- REQ-008: Port payload_i, input, PayloadWidth: the decoded instruction, packed MSB-first in this order:
  - opcode(12), primary opcode(6), address(64), funcUnit(3), majId(64), minId(7), is64Bit(1);
  - pid(20), tid(16), op1rw(2), op2rw(2), {op1isReg, op2isReg, immIsExtended, immIsShifted}(4), body(26).
- REQ-009: Port stall_o, input-side, output, 1: drives the decoders' stall_i.
- REQ-010: Port valid_o, output, 1: head entry presented to dispatch.
- REQ-011: Port payload_o, output, PayloadWidth: head entry contents.
- REQ-012: Port ready_i, input, 1: dispatch accepts the head this cycle.
- REQ-013: Port count_o, output, CountWidth: current occupancy.
- REQ-014: Port overflow_o, output, 1: sticky error flag.

Function
- REQ-015: Circular FIFO with read pointer, write pointer and occupancy counter.
  - Pointers are log2(Depth) bits and wrap modulo Depth.
- REQ-016: A write occurs when enable_i=1 and the queue is not full.
  - payload_i is stored at the write pointer.
  - The write pointer increments on the same edge.
- REQ-017: A read occurs when valid_o=1 and ready_i=1.
  - The read pointer increments on that edge.
- REQ-018: valid_o=1 iff count_o>0; payload_o is the entry at the read pointer.
  - Write-to-valid_o latency is 1 cycle.
- REQ-019: A simultaneous write and read leaves count_o unchanged.
  - This holds in every state, including full; both pointers advance.
- REQ-020: stall_o=1 iff count_o >= Depth-1.
  - This reserves one slot for the instruction already in flight in the one-cycle decoder.
- REQ-021: Write while full with no simultaneous read:
  - The entry is dropped.
  - No pointer or count change.
  - overflow_o is set to 1 and stays 1 until reset.
- REQ-022: flush_i=1 takes priority over writes and reads on that edge.
  - Pointers and count go to 0; overflow_o is unchanged.
  - valid_o=0 on the next cycle.
- REQ-023: Storage contents are not reset or flushed; only pointers, count and flags are.
- REQ-024: count_o never exceeds Depth and never underflows.
  - A read with count_o=0 cannot occur, because valid_o=0.

Reset
- REQ-025: While reset_i=0 at a rising edge, the following are set to 0 on that edge:
  - read pointer, write pointer, count_o, overflow_o.
  - Consequently valid_o=0 and stall_o=0.
- REQ-026: Reset takes priority over flush_i, enable_i and ready_i.
  - A reset mid-stream discards all entries; enable_i in that cycle is ignored.
- REQ-027: payload_o is don't-care while valid_o=0.

Configuration
- REQ-028: Macro DECODE_QUEUE_BYPASS_EN.
  - Defined: when count_o=0, enable_i=1 and ready_i=1, the queue does the following in the same cycle:
    - drives valid_o=1 and payload_o=payload_i combinationally;
    - does not store the entry; count is unchanged.
  - Defined, with count_o=0, enable_i=1, ready_i=0: the entry is written normally.
  - Not defined: no combinational path from enable_i/payload_i to valid_o/payload_o.
    - Minimum latency is 1 cycle, per REQ-018.
- REQ-029: With the macro not defined, all outputs are functions of registered state only.

Verification
- REQ-030: Reset, then 4 writes of payloads 1..4 with ready_i=0 -> the following sequence:
  - count_o 1,2,3,4;
  - stall_o=1 from count 3;
  - valid_o=1 with payload_o=1.
- REQ-031: Full queue (4), enable_i=1 payload 5, ready_i=0 -> payload 5 dropped.
  - count_o stays 4 and overflow_o=1 thereafter.
  - Drain with ready_i=1 yields 1,2,3,4.
- REQ-032: Full queue, enable_i=1 and ready_i=1 in the same cycle -> count_o stays 4.
  - Head advances; the new entry is appended at the tail.
  - No overflow.
- REQ-033: 10 writes of payloads 0..9 with ready_i=1 continuously (pointer wrap) -> outputs 0..9 in order.
  - Macro undefined: each output one cycle after its write.
  - count_o <= 1 throughout.
- REQ-034: 3 entries queued, flush_i=1 with enable_i=1 -> next cycle count_o=0, valid_o=0.
  - The concurrent entry is discarded.
- REQ-035: Macro defined, empty queue, enable_i=1 payload 0xA5, ready_i=1 -> same cycle valid_o=1, payload_o=0xA5.
  - count_o remains 0.
